exec_seq: RTL

//   Multi-cycle instruction sequencer for the MSP430 core. Takes decoded fields, steps each instruction through

---
 rtl/exec_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/exec_seq.sv
// Multi-cycle instruction sequencer for the MSP430 core.
// Steps each instruction through fetch, extension, operand, execute and writeback states.
module exec_seq #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fmt,
    input  logic [1:0] as_mode,
    input  logic       ad_mode,
    input  logic [3:0] src_reg,
    input  logic       rw_en,
    input  logic       dst_rd_skip,
    input  logic       stack_op,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mab_sel,
    output logic [1:0] md_sel,
    output logic       ir_load,
    output logic       ext_src_ld,
    output logic       ext_dst_ld,
    output logic       pc_inc,
    output logic       pc_jmp,
    output logic       reg_we,
    output logic       sr_we,
    output logic       src_autoinc,
    output logic       sp_dec,
    output logic       bus_err,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StSrcExt,
        StSrcRd,
        StDstExt,
        StDstRd,
        StExec,
        StStack,
        StWbMem
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic is_fmt_i, is_fmt_ii, is_fmt_j;
    logic cg, need_src_ext, need_src_rd, need_dst_ext, need_dst_rd, mem_dst;
    logic is_mem, timeout;
    state_e after_fetch, after_src_ext, after_src_rd, after_dst_ext;

    assign is_fmt_i  = (fmt == 2'd1);
    assign is_fmt_ii = (fmt == 2'd2);
    assign is_fmt_j  = (fmt == 2'd3);

    // Constant generator: R3 in any mode, R2 in the two indirect modes.
    assign cg = (src_reg == 4'd3) || ((src_reg == 4'd2) && as_mode[1]);

    assign need_src_ext = ((as_mode == 2'b01) && !cg) ||
                          ((as_mode == 2'b11) && (src_reg == 4'd0));
    assign need_src_rd  = ((as_mode == 2'b01) && !cg) ||
                          (as_mode[1] && (src_reg != 4'd0) && (src_reg != 4'd2) &&
                           (src_reg != 4'd3));
    assign need_dst_ext = is_fmt_i && ad_mode;
    assign need_dst_rd  = is_fmt_i && ad_mode && !dst_rd_skip;
    assign mem_dst      = (is_fmt_i && ad_mode) ||
                          (is_fmt_ii && (as_mode != 2'b00) && !stack_op);

    assign is_mem = (state_q == StFetch)  || (state_q == StSrcExt) || (state_q == StSrcRd) ||
                    (state_q == StDstExt) || (state_q == StDstRd)  || (state_q == StStack) ||
                    (state_q == StWbMem);
    // An ack on the final waiting cycle still completes the access.
    assign timeout = is_mem && !mem_ack && (cnt_q == CntW'(MEM_TIMEOUT));

    always_comb begin
        after_dst_ext = need_dst_rd  ? StDstRd  : StExec;
        after_src_rd  = need_dst_ext ? StDstExt : after_dst_ext;
        after_src_ext = need_src_rd  ? StSrcRd  : after_src_rd;
        if (fmt == 2'd0) begin
            after_fetch = StFetch;
        end else if (is_fmt_j) begin
            after_fetch = StExec;
        end else begin
            after_fetch = need_src_ext ? StSrcExt : after_src_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (is_mem && !mem_ack && !timeout) ? cnt_q + CntW'(1) : '0;
        if (timeout) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StFetch;
                StFetch:  if (mem_ack) state_d = after_fetch;
                StSrcExt: if (mem_ack) state_d = after_src_ext;
                StSrcRd:  if (mem_ack) state_d = after_src_rd;
                StDstExt: if (mem_ack) state_d = after_dst_ext;
                StDstRd:  if (mem_ack) state_d = StExec;
                StExec: begin
                    if (!is_fmt_j && rw_en && mem_dst) begin
                        state_d = StWbMem;
                    end else if (is_fmt_ii && stack_op) begin
                        state_d = StStack;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StStack:  if (mem_ack) state_d = StFetch;
                StWbMem:  if (mem_ack) state_d = StFetch;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_req     = is_mem;
        mem_we      = 1'b0;
        mab_sel     = 2'd0;
        md_sel      = 2'd0;
        ir_load     = 1'b0;
        ext_src_ld  = 1'b0;
        ext_dst_ld  = 1'b0;
        pc_inc      = 1'b0;
        pc_jmp      = 1'b0;
        reg_we      = 1'b0;
        sr_we       = 1'b0;
        src_autoinc = 1'b0;
        sp_dec      = 1'b0;
        bus_err     = timeout;
        // IDLE is the reset state and keeps every output low.
        busy        = (state_q != StFetch) && (state_q != StIdle);
        unique case (state_q)
            StFetch: begin
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            StSrcExt: begin
                ext_src_ld = mem_ack;
                pc_inc     = mem_ack;
            end
            StSrcRd: begin
                mab_sel     = (as_mode == 2'b01) ? 2'd1 : 2'd2;
                md_sel      = 2'd1;
                src_autoinc = mem_ack && (as_mode == 2'b11);
            end
            StDstExt: begin
                ext_dst_ld = mem_ack;
                pc_inc     = mem_ack;
            end
            StDstRd: begin
                mab_sel = 2'd1;
                md_sel  = 2'd1;
            end
            StExec: begin
                sr_we  = !is_fmt_j;
                pc_jmp = is_fmt_j;
                reg_we = rw_en && ((is_fmt_i && !ad_mode) ||
                                   (is_fmt_ii && (as_mode == 2'b00)));
            end
            StStack: begin
                sp_dec  = (cnt_q == '0);
                mab_sel = 2'd3;
                mem_we  = 1'b1;
            end
            StWbMem: begin
                mab_sel = 2'd1;
                mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
